// File: rtl/uart_debug_pkg.sv
// rtl/uart_debug_pkg.sv - shared address map, CTRL bit indices and STAT field offsets for the UART debug monitor
package uart_debug_pkg;

    localparam logic [7:0] DBG_LIVE0 = 8'h08;
    localparam logic [7:0] DBG_LIVE1 = 8'h0C;
    localparam logic [7:0] DBG_CTRL  = 8'h10;
    localparam logic [7:0] DBG_SNAP0 = 8'h14;
    localparam logic [7:0] DBG_SNAP1 = 8'h18;
    localparam logic [7:0] DBG_STAT  = 8'h1C;

    localparam int CTRL_CAPTURE = 0;
    localparam int CTRL_ARM     = 1;
    localparam int CTRL_CLR_WM  = 2;
    localparam int CTRL_CLR_EV  = 3;
    localparam int CTRL_DISARM  = 4;

    localparam int STAT_RF_MAX_LSB = 0;
    localparam int STAT_TF_MAX_LSB = 8;
    localparam int STAT_FE_CNT_LSB = 16;
    localparam int STAT_OV_CNT_LSB = 24;

    // lsr bits that act as error events
    localparam int LSR_OE = 1;
    localparam int LSR_FE = 3;
    localparam int LSR_BI = 4;

endpackage

// File: rtl/uart_debug_satcnt.sv
// rtl/uart_debug_satcnt.sv - 8-bit saturating rising-edge counter with synchronous clear
module uart_debug_satcnt (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic       bit_i,
    output logic [7:0] cnt_o
);

    logic       prev_q;
    logic [7:0] cnt_q, cnt_d;

    // clear takes priority over an edge arriving on the same cycle
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (bit_i && !prev_q && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            prev_q <= bit_i;
            cnt_q  <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/uart_debug_mon.sv
// rtl/uart_debug_mon.sv - UART16550 debug monitor: live readout, snapshot, high-water marks, event counters (UART_DEBUG_EVCNT_EN)
module uart_debug_mon
    import uart_debug_pkg::*;
#(
    parameter int ADDR_WIDTH     = 5,
    parameter int FIFO_COUNTER_W = 5
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic [ADDR_WIDTH-1:0]     wb_adr_i,
    input  logic                      wb_re_i,
    input  logic                      wb_we_i,
    input  logic [31:0]               wb_dat_i,
    output logic [31:0]               wb_dat32_o,
    input  logic [3:0]                ier,
    input  logic [3:0]                iir,
    input  logic [1:0]                fcr,
    input  logic [4:0]                mcr,
    input  logic [7:0]                lcr,
    input  logic [7:0]                msr,
    input  logic [7:0]                lsr,
    input  logic [FIFO_COUNTER_W-1:0] rf_count,
    input  logic [FIFO_COUNTER_W-1:0] tf_count,
    input  logic [3:0]                rstate,
    input  logic [2:0]                tstate,
    output logic                      dbg_trig_o
);

    localparam logic [ADDR_WIDTH-1:0] A_LIVE0 = ADDR_WIDTH'(DBG_LIVE0);
    localparam logic [ADDR_WIDTH-1:0] A_LIVE1 = ADDR_WIDTH'(DBG_LIVE1);
    localparam logic [ADDR_WIDTH-1:0] A_CTRL  = ADDR_WIDTH'(DBG_CTRL);
    localparam logic [ADDR_WIDTH-1:0] A_SNAP0 = ADDR_WIDTH'(DBG_SNAP0);
    localparam logic [ADDR_WIDTH-1:0] A_SNAP1 = ADDR_WIDTH'(DBG_SNAP1);
    localparam logic [ADDR_WIDTH-1:0] A_STAT  = ADDR_WIDTH'(DBG_STAT);

    logic [31:0] live0_w, live1_w, stat_w, ctrl_rd_w, rd_sel_w;
    logic [31:0] rd_q, rd_d;
    logic [31:0] snap0_q, snap0_d, snap1_q, snap1_d;
    logic        snap_valid_q, snap_valid_d;
    logic        arm_q, arm_d;
    logic        trig_q;
    logic [FIFO_COUNTER_W-1:0] rf_max_q, rf_max_d, tf_max_q, tf_max_d;
    logic [2:0]  trig_prev_q, trig_src_w, trig_rise_w;
    logic        ctrl_wr_w, capture_w, fire_w;
    logic [7:0]  ov_cnt_w, fe_cnt_w;
    logic        unused_dat;

    assign unused_dat = ^wb_dat_i[31:5];

    assign live0_w = {msr, lcr, iir, ier, lsr};
    assign live1_w = 32'({fcr, mcr, rf_count, rstate, tf_count, tstate});

    assign ctrl_wr_w   = wb_we_i && (wb_adr_i == A_CTRL);
    assign trig_src_w  = {lsr[LSR_BI], lsr[LSR_FE], lsr[LSR_OE]};
    assign trig_rise_w = trig_src_w & ~trig_prev_q;
    assign fire_w      = arm_q && (|trig_rise_w);
    assign capture_w   = fire_w || (ctrl_wr_w && wb_dat_i[CTRL_CAPTURE]);

`ifdef UART_DEBUG_EVCNT_EN
    logic clr_ev_w;
    assign clr_ev_w = ctrl_wr_w && wb_dat_i[CTRL_CLR_EV];

    uart_debug_satcnt u_ov_cnt (
        .clk_i  (wb_clk_i),
        .rst_ni (wb_rst_i),
        .clr_i  (clr_ev_w),
        .bit_i  (lsr[LSR_OE]),
        .cnt_o  (ov_cnt_w)
    );

    uart_debug_satcnt u_fe_cnt (
        .clk_i  (wb_clk_i),
        .rst_ni (wb_rst_i),
        .clr_i  (clr_ev_w),
        .bit_i  (lsr[LSR_FE]),
        .cnt_o  (fe_cnt_w)
    );
`else
    logic unused_clr_ev;
    assign unused_clr_ev = wb_dat_i[CTRL_CLR_EV];
    assign ov_cnt_w      = '0;
    assign fe_cnt_w      = '0;
`endif

    always_comb begin
        stat_w = '0;
        stat_w[STAT_RF_MAX_LSB +: 8] = 8'(rf_max_q);
        stat_w[STAT_TF_MAX_LSB +: 8] = 8'(tf_max_q);
        stat_w[STAT_FE_CNT_LSB +: 8] = fe_cnt_w;
        stat_w[STAT_OV_CNT_LSB +: 8] = ov_cnt_w;
    end

    assign ctrl_rd_w = {30'b0, arm_q, snap_valid_q};

    // read mux sees pre-edge state, so a same-cycle write is not visible yet
    always_comb begin
        rd_sel_w = '0;
        case (wb_adr_i)
            A_LIVE0: rd_sel_w = live0_w;
            A_LIVE1: rd_sel_w = live1_w;
            A_CTRL:  rd_sel_w = ctrl_rd_w;
            A_SNAP0: rd_sel_w = snap0_q;
            A_SNAP1: rd_sel_w = snap1_q;
            A_STAT:  rd_sel_w = stat_w;
            default: rd_sel_w = '0;
        endcase
    end

    always_comb begin
        rd_d         = wb_re_i ? rd_sel_w : rd_q;
        snap0_d      = snap0_q;
        snap1_d      = snap1_q;
        snap_valid_d = snap_valid_q;
        arm_d        = arm_q;
        rf_max_d     = rf_max_q;
        tf_max_d     = tf_max_q;

        if (capture_w) begin
            snap0_d      = live0_w;
            snap1_d      = live1_w;
            snap_valid_d = 1'b1;
        end

        if (fire_w) begin
            arm_d = 1'b0;
        end else if (ctrl_wr_w && wb_dat_i[CTRL_DISARM]) begin
            arm_d = 1'b0;
        end else if (ctrl_wr_w && wb_dat_i[CTRL_ARM]) begin
            arm_d = 1'b1;
        end

        if (ctrl_wr_w && wb_dat_i[CTRL_CLR_WM]) begin
            rf_max_d = rf_count;
            tf_max_d = tf_count;
        end else begin
            if (rf_count > rf_max_q) rf_max_d = rf_count;
            if (tf_count > tf_max_q) tf_max_d = tf_count;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            rd_q         <= '0;
            snap0_q      <= '0;
            snap1_q      <= '0;
            snap_valid_q <= 1'b0;
            arm_q        <= 1'b0;
            trig_q       <= 1'b0;
            rf_max_q     <= '0;
            tf_max_q     <= '0;
            trig_prev_q  <= '0;
        end else begin
            rd_q         <= rd_d;
            snap0_q      <= snap0_d;
            snap1_q      <= snap1_d;
            snap_valid_q <= snap_valid_d;
            arm_q        <= arm_d;
            trig_q       <= fire_w;
            rf_max_q     <= rf_max_d;
            tf_max_q     <= tf_max_d;
            trig_prev_q  <= trig_src_w;
        end
    end

    assign wb_dat32_o = rd_q;
    assign dbg_trig_o = trig_q;

endmodule

// File: tb/tb_uart_debug_mon.sv
// tb/tb_uart_debug_mon.sv - self-checking bench for uart_debug_mon against a behavioural model
module tb_uart_debug_mon;

    localparam int AW = 5;
    localparam int W  = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] adr;
    logic          re, we;
    logic [31:0]   dat;
    logic [31:0]   rdata;
    logic          trig;
    logic [3:0]    ier, iir, rstate;
    logic [1:0]    fcr;
    logic [4:0]    mcr;
    logic [7:0]    lcr, msr, lsr;
    logic [W-1:0]  rf, tf;
    logic [2:0]    tstate;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_snap0, m_snap1;
    bit          m_sv, m_arm, m_trig;
    int          m_rfmax, m_tfmax, m_ov, m_fe;
    bit          p_oe, p_fe, p_bi;

    always #5 clk = ~clk;

    uart_debug_mon #(.ADDR_WIDTH(AW), .FIFO_COUNTER_W(W)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst_n),
        .wb_adr_i   (adr),
        .wb_re_i    (re),
        .wb_we_i    (we),
        .wb_dat_i   (dat),
        .wb_dat32_o (rdata),
        .ier        (ier),
        .iir        (iir),
        .fcr        (fcr),
        .mcr        (mcr),
        .lcr        (lcr),
        .msr        (msr),
        .lsr        (lsr),
        .rf_count   (rf),
        .tf_count   (tf),
        .rstate     (rstate),
        .tstate     (tstate),
        .dbg_trig_o (trig)
    );

    function automatic logic [31:0] f_live0();
        return (32'(msr) << 24) | (32'(lcr) << 16) | (32'(iir) << 12) | (32'(ier) << 8) | 32'(lsr);
    endfunction

    function automatic logic [31:0] f_live1();
        return 32'(tstate) | (32'(tf) << 3) | (32'(rstate) << (3 + W)) | (32'(rf) << (7 + W))
             | (32'(mcr) << (7 + 2 * W)) | (32'(fcr) << (12 + 2 * W));
    endfunction

    function automatic logic [31:0] f_read(input logic [7:0] a);
        case (a)
            8'h08: return f_live0();
            8'h0C: return f_live1();
            8'h10: return {30'b0, m_arm, m_sv};
            8'h14: return m_snap0;
            8'h18: return m_snap1;
            8'h1C: return 32'(m_ov * 16777216 + m_fe * 65536 + m_tfmax * 256 + m_rfmax);
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_snap0 = 0; m_snap1 = 0; m_sv = 0; m_arm = 0; m_trig = 0;
        m_rfmax = 0; m_tfmax = 0; m_ov = 0; m_fe = 0;
        p_oe = 0; p_fe = 0; p_bi = 0;
    endtask

    // what one rising clock edge does to the visible state, given the inputs now applied
    task automatic model_edge();
        bit wc, r_oe, r_fe, r_bi, fire;
        wc   = we && (adr == 5'h10);
        r_oe = lsr[1] && !p_oe;
        r_fe = lsr[3] && !p_fe;
        r_bi = lsr[4] && !p_bi;
        fire = m_arm && (r_oe || r_fe || r_bi);
        if (fire || (wc && dat[0])) begin
            m_snap0 = f_live0();
            m_snap1 = f_live1();
            m_sv    = 1;
        end
        if (fire)                m_arm = 0;
        else if (wc && dat[4])   m_arm = 0;
        else if (wc && dat[1])   m_arm = 1;
        m_trig = fire;
        if (wc && dat[2]) begin
            m_rfmax = int'(rf);
            m_tfmax = int'(tf);
        end else begin
            if (int'(rf) > m_rfmax) m_rfmax = int'(rf);
            if (int'(tf) > m_tfmax) m_tfmax = int'(tf);
        end
`ifdef UART_DEBUG_EVCNT_EN
        if (wc && dat[3]) begin
            m_ov = 0;
            m_fe = 0;
        end else begin
            if (r_oe && m_ov < 255) m_ov++;
            if (r_fe && m_fe < 255) m_fe++;
        end
`endif
        p_oe = lsr[1]; p_fe = lsr[3]; p_bi = lsr[4];
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check("trig", {31'b0, trig}, {31'b0, m_trig});
    endtask

    task automatic rd(input logic [7:0] a, input string tag, output logic [31:0] obs);
        logic [31:0] e;
        adr = a[AW-1:0];
        re  = 1'b1;
        e   = f_read(a);
        tick();
        re  = 1'b0;
        obs = rdata;
        check(tag, rdata, e);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        adr = a[AW-1:0];
        we  = 1'b1;
        dat = d;
        tick();
        we  = 1'b0;
        dat = '0;
    endtask

    task automatic rand_inputs();
        ier = 4'($urandom); iir = 4'($urandom); fcr = 2'($urandom); mcr = 5'($urandom);
        lcr = 8'($urandom); msr = 8'($urandom); lsr = 8'($urandom);
        rf = W'($urandom); tf = W'($urandom); rstate = 4'($urandom); tstate = 3'($urandom);
    endtask

    initial begin
        logic [31:0] obs, saved;
        logic [7:0]  addrs[6];
        logic [7:0]  bad[6];
        addrs = '{8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C};
        bad   = '{8'h00, 8'h04, 8'h07, 8'h0D, 8'h11, 8'h1D};

        rst_n = 0; adr = '0; re = 0; we = 0; dat = '0;
        ier = 0; iir = 0; fcr = 0; mcr = 0; lcr = 0; msr = 0; lsr = 0;
        rf = 0; tf = 0; rstate = 0; tstate = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_rdata", rdata, 32'h0);
        check("rst_trig", {31'b0, trig}, 32'h0);
        rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            rd(addrs[i], "rst_read_model", obs);
            check("rst_read_zero", obs, 32'h0);
        end

        lsr = 8'h60; ier = 4'h5; iir = 4'hC; lcr = 8'h03; msr = 8'hB0;
        rd(8'h08, "live0_model", obs);
        check("live0_const", obs, 32'hB003C560);

        for (int i = 0; i < 8; i++) begin
            rand_inputs();
            rd(8'h08, "live0_rand", obs);
            rd(8'h0C, "live1_rand", obs);
            rd(bad[$urandom_range(0, 5)], "unmapped_read", obs);
            wr(bad[$urandom_range(0, 5)], $urandom);
            rd(8'h10, "ctrl_after_bad_wr", obs);
            rd(8'h1C, "stat_rand", obs);
        end
        lsr = 0;
        tick();

        rf = 3; tstate = 2;
        wr(8'h10, 32'h1);
        rand_inputs();
        lsr = 0;
        rd(8'h18, "snap1_model", obs);
        check("snap1_rf", 32'(obs[7 + W +: W]), 32'd3);
        check("snap1_tstate", 32'(obs[2:0]), 32'd2);
        rd(8'h14, "snap0_model", obs);
        rd(8'h10, "ctrl_after_cap", obs);
        check("ctrl_after_cap_const", obs, 32'h1);

        wr(8'h10, 32'h2);
        rd(8'h10, "ctrl_armed", obs);
        check("ctrl_armed_const", obs, 32'h3);
        lsr = 8'h02;
        tick();
        check("trig_pulse", {31'b0, trig}, 32'h1);
        tick();
        check("trig_one_cycle", {31'b0, trig}, 32'h0);
        rd(8'h10, "ctrl_fired", obs);
        check("ctrl_fired_const", obs, 32'h1);
        rd(8'h14, "snap0_fired", saved);
        check("snap0_oe_bit", 32'(saved[1]), 32'h1);
        lsr = 0;
        tick();
        msr = ~msr;
        lsr = 8'h02;
        tick();
        check("no_retrigger", {31'b0, trig}, 32'h0);
        rd(8'h14, "snap0_held", obs);
        check("snap0_held_const", obs, saved);

        lsr = 0;
        tick();
        adr = 5'h10; we = 1; dat = 32'h2; lsr = 8'h08;
        tick();
        we = 0; dat = 0;
        check("arm_same_edge_nofire", {31'b0, trig}, 32'h0);
        rd(8'h10, "ctrl_arm_same_edge", obs);
        check("ctrl_arm_same_edge_const", obs, 32'h3);
        lsr = 8'h18;
        tick();
        check("break_fire", {31'b0, trig}, 32'h1);
        lsr = 0;
        tick();
        wr(8'h10, 32'h2);
        adr = 5'h10; we = 1; dat = 32'h1; lsr = 8'h02;
        tick();
        we = 0; dat = 0;
        check("manual_and_auto", {31'b0, trig}, 32'h1);
        rd(8'h10, "ctrl_manual_and_auto", obs);
        check("ctrl_manual_and_auto_const", obs, 32'h1);
        lsr = 0;
        tick();

        wr(8'h10, 32'h2);
        wr(8'h10, 32'h10);
        rd(8'h10, "ctrl_disarmed", obs);
        check("ctrl_disarmed_const", obs, 32'h1);
        lsr = 8'h10;
        tick();
        check("disarmed_nofire", {31'b0, trig}, 32'h0);
        lsr = 0;
        tick();

        rf = 2; tf = 1;
        wr(8'h10, 32'h4);
        rf = 7;
        tick();
        rf = 4;
        tick();
        rd(8'h1C, "wm_peak", obs);
        check("wm_peak_const", 32'(obs[7:0]), 32'd7);
        wr(8'h10, 32'h4);
        rd(8'h1C, "wm_clear", obs);
        check("wm_clear_const", 32'(obs[7:0]), 32'd4);
        for (int i = 0; i < 20; i++) begin
            rf = W'($urandom); tf = W'($urandom);
            if ($urandom_range(0, 4) == 0) wr(8'h10, 32'h4);
            else tick();
            if (i % 5 == 4) rd(8'h1C, "wm_rand", obs);
        end

        wr(8'h10, 32'h8);
        for (int i = 0; i < 300; i++) begin
            lsr = {4'b0, 1'b1, 1'b0, 1'($urandom), 1'b0};
            tick();
            lsr = 0;
            tick();
        end
        rd(8'h1C, "stat_after_pulses", obs);
`ifdef UART_DEBUG_EVCNT_EN
        check("fe_saturated", 32'(obs[23:16]), 32'd255);
`else
        check("stat_hi_zero", 32'(obs[31:16]), 32'd0);
`endif
        adr = 5'h10; we = 1; dat = 32'h8; lsr = 8'h0A;
        tick();
        we = 0; dat = 0;
        rd(8'h1C, "stat_clr_ev", obs);
        check("fe_clr_wins", 32'(obs[23:16]), 32'd0);
        check("ov_clr_wins", 32'(obs[31:24]), 32'd0);
        lsr = 0;
        tick();
        lsr = 8'h08;
        tick();
        rd(8'h1C, "stat_one_edge", obs);

        rand_inputs();
        rd(8'h08, "live0_pre_reset", obs);
        lsr = 0; rf = 0; tf = 0;
        #2;
        rst_n = 0;
        #1;
        check("async_rst_rdata", rdata, 32'h0);
        check("async_rst_trig", {31'b0, trig}, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        rd(8'h10, "ctrl_post_reset", obs);
        check("ctrl_post_reset_const", obs, 32'h0);
        rd(8'h14, "snap0_post_reset", obs);
        check("snap0_post_reset_const", obs, 32'h0);
        rd(8'h1C, "stat_post_reset", obs);
        check("stat_post_reset_const", obs, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
